// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling, valid/ack holding register.
// Define UART_RX_PARITY_EN to add the PARITY state and the parity_err output.
module uart_rx_ctrl #(
    parameter int OVER_SAMPL     = 16,
    parameter int OVER_SAMPL_BIT = 5,
    parameter int DATA_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [OVER_SAMPL_BIT-1:0] CNT_MID = OVER_SAMPL_BIT'(OVER_SAMPL / 2 - 1);
    localparam logic [OVER_SAMPL_BIT-1:0] CNT_MAX = OVER_SAMPL_BIT'(OVER_SAMPL - 1);
    localparam logic [OVER_SAMPL_BIT-1:0] CNT_ONE = OVER_SAMPL_BIT'(1);
    localparam logic [BC_W-1:0]           BIT_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0]           BIT_ONE  = BC_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY   = 3'd3,
`endif
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_s1_q, rx_s2_q;
    logic                    rxs;
    logic [OVER_SAMPL_BIT-1:0] cnt_q, cnt_d;
    logic [BC_W-1:0]         bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]    shreg_q, shreg_d;
    logic [DATA_BITS-1:0]    data_q;
    logic                    data_valid_q, frame_err_q, overrun_q;
    logic                    hit, last_bit;
    logic                    shift_en, commit, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                    par_smp;
    logic                    par_bad_q, par_bad_d;
    logic                    parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rxs      = rx_s2_q;
    assign hit      = en && (cnt_q == CNT_MID);
    assign last_bit = (bitcnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (en && !rxs) state_d = START;
            START:    if (hit) state_d = rxs ? IDLE : DATA;
            DATA: begin
                if (hit && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:   if (hit) state_d = STOP;
`endif
            STOP:     if (hit) state_d = rxs ? IDLE : BRK_WAIT;
            // A held-low line must return high before a new start is accepted.
            BRK_WAIT: if (en && rxs) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        shift_en = 1'b0;
        commit   = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        case (state_q)
            DATA:    shift_en = hit;
`ifdef UART_RX_PARITY_EN
            PARITY:  par_smp = hit;
`endif
            STOP: begin
                commit   = hit && rxs;
                ferr_set = hit && !rxs;
            end
            default: ;
        endcase
    end

    // The detection tick counts as tick 0, so the counter is already 1 on entering START.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == IDLE || state_d == BRK_WAIT) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
        end

        bitcnt_d = bitcnt_q;
        if (state_q == START) begin
            bitcnt_d = '0;
        end else if (shift_en && !last_bit) begin
            bitcnt_d = bitcnt_q + BIT_ONE;
        end

        shreg_d = shift_en ? {rxs, shreg_q[DATA_BITS-1:1]} : shreg_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_smp ? ^{shreg_q, rxs} : par_bad_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Holding register: a commit always wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= ferr_set;
            if (commit) begin
                data_q       <= shreg_q;
                data_valid_q <= 1'b1;
                overrun_q    <= data_valid_q && !data_ack;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_bad_q;
`endif
            end else begin
                overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
                if (data_ack) data_valid_q <= 1'b0;
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level event model plus directed literal checks.
module tb_uart_rx_ctrl;

    localparam int K_BUSY_ON  = 0;
    localparam int K_BUSY_OFF = 1;
    localparam int K_COMMIT   = 2;
    localparam int K_FERR     = 3;
    localparam int K_PERR     = 4;

    logic       clk = 1'b0;
    logic       rst, en, rx, data_ack;
    logic [7:0] data;
    logic       data_valid, frame_err, overrun, busy;
    logic       perr_w;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } ev_t;
    ev_t evq[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   ovr_seen = 0;
    int   ferr_seen = 0;
    logic abort = 1'b0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0, m_busy = 1'b0;

    uart_rx_ctrl #(.OVER_SAMPL(16), .OVER_SAMPL_BIT(5), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rx         (rx),
        .data_ack   (data_ack),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (perr_w),
`endif
        .busy       (busy)
    );

`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // Model: events scheduled by the frame sender, plus holding-register rules.
    always @(posedge clk) begin : model
        logic       cm, fe, pe, bon, boff;
        logic [7:0] cv;
        cyc <= cyc + 1;
        cm = 1'b0; fe = 1'b0; pe = 1'b0; bon = 1'b0; boff = 1'b0; cv = 8'h00;
        if (!rst) begin
            m_data <= 8'h00; m_valid <= 1'b0; m_ferr <= 1'b0;
            m_ovr <= 1'b0; m_perr <= 1'b0; m_busy <= 1'b0;
            evq.delete();
        end else begin
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].cyc == cyc + 1) begin
                    case (evq[i].kind)
                        K_BUSY_ON:  bon = 1'b1;
                        K_BUSY_OFF: boff = 1'b1;
                        K_COMMIT:   begin cm = 1'b1; cv = evq[i].val; end
                        K_FERR:     fe = 1'b1;
                        K_PERR:     pe = 1'b1;
                        default: ;
                    endcase
                    evq.delete(i);
                end
            end
            m_ferr <= fe;
            if (cm) begin
                m_data  <= cv;
                m_valid <= 1'b1;
                m_ovr   <= m_valid && !data_ack;
                m_perr  <= pe;
            end else begin
                m_ovr  <= 1'b0;
                m_perr <= 1'b0;
                if (data_ack) m_valid <= 1'b0;
            end
            if (bon) m_busy <= 1'b1;
            if (boff) m_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("outputs{perr,busy,ovr,ferr,vld,data}",
                  {3'b000, perr_w, busy, overrun, frame_err, data_valid, data},
                  {3'b000, m_perr, m_busy, m_ovr, m_ferr, m_valid, m_data});
            if (overrun === 1'b1) ovr_seen++;
            if (frame_err === 1'b1) ferr_seen++;
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) tick1();
    endtask

    task automatic push_ev(input int c, input int k, input logic [7:0] v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        evq.push_back(e);
    endtask

    // par_mode: -1 no parity bit, otherwise the parity bit value sent.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int par_mode);
        logic bitv[12];
        int   n, t0, done;
        logic par_b;
        t0    = cyc + 2;
        par_b = (par_mode == 1);
        n     = 9;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[i+1] = b[i];
        if (par_mode >= 0) begin bitv[n] = par_b; n++; end
        bitv[n] = stop_b;
        n++;
        done = t0 + 7 + 16 * (n - 1) + 1;
        push_ev(t0 + 1, K_BUSY_ON, 8'h00);
        if (stop_b) begin
            push_ev(done, K_COMMIT, b);
            push_ev(done, K_BUSY_OFF, 8'h00);
            if (par_mode >= 0 && ((^b) ^ par_b)) push_ev(done, K_PERR, 8'h00);
        end else begin
            push_ev(done, K_FERR, 8'h00);
        end
        for (int i = 0; i < n; i++) begin
            rx = bitv[i];
            for (int j = 0; j < 16; j++) begin
                if (abort) begin rx = 1'b1; return; end
                tick1();
            end
        end
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        tick1();
        data_ack = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        rst = 1'b0; en = 1'b1; rx = 1'b1; data_ack = 1'b0;
        repeat (3) tick1();
        check("reset data", {8'h00, data}, 16'h0000);
        check("reset valid", {15'h0, data_valid}, 16'h0000);
        check("reset busy", {15'h0, busy}, 16'h0000);
        rst = 1'b1;
        repeat (5) tick1();

        // Clean 0xA5: valid rises 152 ticks after the start tick.
        e0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                at_cycle(e0 + 153);
                check("A5 valid before rise", {15'h0, data_valid}, 16'h0000);
                at_cycle(e0 + 154);
                check("A5 valid rise", {15'h0, data_valid}, 16'h0001);
                check("A5 data", {8'h00, data}, 16'h00A5);
                check("A5 frame_err", {15'h0, frame_err}, 16'h0000);
            end
        join
        repeat (20) tick1();
        check("A5 held unacked", {15'h0, data_valid}, 16'h0001);
        ack_pulse();
        check("A5 ack clears", {15'h0, data_valid}, 16'h0000);
        repeat (5) tick1();

        // Glitch: 4 clocks low then high.
        e0 = cyc;
        push_ev(e0 + 3, K_BUSY_ON, 8'h00);
        push_ev(e0 + 10, K_BUSY_OFF, 8'h00);
        rx = 1'b0;
        repeat (4) tick1();
        rx = 1'b1;
        at_cycle(e0 + 9);
        check("glitch busy", {15'h0, busy}, 16'h0001);
        at_cycle(e0 + 10);
        check("glitch busy released", {15'h0, busy}, 16'h0000);
        repeat (20) tick1();
        check("glitch no valid", {15'h0, data_valid}, 16'h0000);
        check("glitch no ferr", ferr_seen[15:0], 16'd0);

        // Bad stop bit, line held low 40 more clocks.
        send_frame(8'h3C, 1'b0, -1);
        repeat (40) tick1();
        check("break busy", {15'h0, busy}, 16'h0001);
        rx = 1'b1;
        push_ev(cyc + 3, K_BUSY_OFF, 8'h00);
        repeat (5) tick1();
        check("break ferr count", ferr_seen[15:0], 16'd1);
        check("break no valid", {15'h0, data_valid}, 16'h0000);
        check("break busy released", {15'h0, busy}, 16'h0000);
        repeat (10) tick1();

        // Overrun: 0x11 unacked then 0x22.
        send_frame(8'h11, 1'b1, -1);
        repeat (10) tick1();
        send_frame(8'h22, 1'b1, -1);
        repeat (10) tick1();
        check("overrun count", ovr_seen[15:0], 16'd1);
        check("overrun data", {8'h00, data}, 16'h0022);
        check("overrun valid", {15'h0, data_valid}, 16'h0001);

        // Ack in the commit cycle: no overrun.
        e0 = cyc;
        fork
            send_frame(8'h33, 1'b1, -1);
            begin
                at_cycle(e0 + 153);
                ack_pulse();
            end
        join
        repeat (10) tick1();
        check("ack at commit no overrun", ovr_seen[15:0], 16'd1);
        check("ack at commit data", {8'h00, data}, 16'h0033);
        check("ack at commit valid", {15'h0, data_valid}, 16'h0001);
        ack_pulse();
        check("ack clears 33", {15'h0, data_valid}, 16'h0000);
        ack_pulse();
        tick1();
        check("ack while idle ignored", {15'h0, data_valid}, 16'h0000);
        repeat (5) tick1();

        // Reset at tick 60 of a frame, released at tick 62.
        e0 = cyc;
        fork
            send_frame(8'h00, 1'b1, -1);
            begin
                at_cycle(e0 + 62);
                rst = 1'b0;
                abort = 1'b1;
                at_cycle(e0 + 63);
                check("midreset data", {8'h00, data}, 16'h0000);
                check("midreset busy", {15'h0, busy}, 16'h0000);
                check("midreset valid", {15'h0, data_valid}, 16'h0000);
                at_cycle(e0 + 64);
                rst = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (10) tick1();
        send_frame(8'h5A, 1'b1, -1);
        repeat (10) tick1();
        check("post-reset data", {8'h00, data}, 16'h005A);
        check("post-reset valid", {15'h0, data_valid}, 16'h0001);
        ack_pulse();
        repeat (5) tick1();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1);
        repeat (10) tick1();
        check("parity ok data", {8'h00, data}, 16'h0007);
        ack_pulse();
        repeat (5) tick1();
        e0 = cyc;
        fork
            send_frame(8'h07, 1'b1, 0);
            begin
                at_cycle(e0 + 170);
                check("parity bad pulse", {14'h0, perr_w, data_valid}, 16'h0003);
            end
        join
        repeat (10) tick1();
        ack_pulse();
        repeat (5) tick1();
`endif

        check("event queue drained", evq.size(), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
